apb_master_bridge: RTL and testbench

Bridges the core-side data bus (req/gnt/rvalid handshake) onto the peripheral APB, acting as the single APB initiator for UART, timer and other APB slaves in the SoC. It accepts one request at a time, runs a complete APB SETUP/ACCESS transfer, and returns read data and error status to the requester. A programmable watchdog terminates transfers whose slave never asserts pready.

---
 rtl/apb_master_bridge.sv | 162 ++++++++++++++++
 tb/tb_apb_master_bridge.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  Module   : apb_master_bridge
//  Purpose  : Bridges the core req/gnt/rvalid data bus onto APB as the sole
//             initiator. One outstanding request at a time. A programmable
//             watchdog aborts transfers whose slave never asserts pready.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module apb_master_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                pclk,
   input  logic                prstn,
   // core-side request/response
   input  logic                req_i,
   input  logic                we_i,
   input  logic [DATA_W/8-1:0] be_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [DATA_W-1:0]   wdata_i,
   output logic                gnt_o,
   output logic                rvalid_o,
   output logic [DATA_W-1:0]   rdata_o,
   output logic                err_o,
   // APB initiator
   output logic                psel,
   output logic                penable,
   output logic                pwrite,
   output logic [ADDR_W-1:0]   paddr,
   output logic [DATA_W-1:0]   pwdata,
   output logic [DATA_W/8-1:0] pstrb,
   input  logic [DATA_W-1:0]   prdata,
   input  logic                pready,
   input  logic                pslverr
);

   // Watchdog counter is at least one bit wide so TIMEOUT=0 still elaborates.
   localparam int                CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]     paddr_q, paddr_d;
   logic [DATA_W-1:0]     pwdata_q, pwdata_d;
   logic [DATA_W/8-1:0]   pstrb_q, pstrb_d;
   logic                  rvalid_q, rvalid_d;
   logic [DATA_W-1:0]     rdata_q, rdata_d;
   logic                  err_q, err_d;

   logic [CNT_W-1:0]      cnt_inc;
   logic                  expire;

   // Watchdog fires on the stalled ACCESS cycle that would bring the count to TIMEOUT.
   assign cnt_inc = count_q + CNT_W'(1);
   assign expire  = (TIMEOUT != 0) && (cnt_inc == CNT_LIMIT);

   // Next-state, APB attribute latching and response generation.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      pwrite_d = pwrite_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      pstrb_d  = pstrb_q;
      rvalid_d = 1'b0;
      rdata_d  = rdata_q;
      err_d    = err_q;
      gnt_o    = 1'b0;

      case (state_q)
         IDLE: begin
            gnt_o = req_i;
            if (req_i) begin
               if (we_i && (be_i == '0)) begin
                  // Write with no lanes enabled completes locally without touching APB.
                  rvalid_d = 1'b1;
                  rdata_d  = '0;
                  err_d    = 1'b0;
               end else begin
                  state_d  = SETUP;
                  count_d  = '0;
                  pwrite_d = we_i;
                  paddr_d  = {addr_i[ADDR_W-1:2], 2'b00};
                  pwdata_d = wdata_i;
                  pstrb_d  = we_i ? be_i : '0;
               end
            end
         end

         SETUP: begin
            state_d = ACCESS;
         end

         ACCESS: begin
            if (pready) begin
               rvalid_d = 1'b1;
               rdata_d  = pwrite_q ? '0 : prdata;
               err_d    = pslverr;
               state_d  = IDLE;
            end else if (expire) begin
               rvalid_d = 1'b1;
               rdata_d  = '0;
               err_d    = 1'b1;
               count_d  = cnt_inc;
               state_d  = IDLE;
            end else if (count_q != '1) begin
               count_d = cnt_inc;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         state_q  <= IDLE;
         count_q  <= '0;
         pwrite_q <= 1'b0;
         paddr_q  <= '0;
         pwdata_q <= '0;
         pstrb_q  <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         pwrite_q <= pwrite_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
         pstrb_q  <= pstrb_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   // psel/penable decode straight from state so reset removes them immediately.
   assign psel     = (state_q != IDLE);
   assign penable  = (state_q == ACCESS);
   assign pwrite   = pwrite_q;
   assign paddr    = paddr_q;
   assign pwdata   = pwdata_q;
   assign pstrb    = pstrb_q;
   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  Module   : tb_apb_master_bridge
//  Purpose  : Directed self-checking bench for apb_master_bridge. One instance
//             has TIMEOUT=8, a second shares all inputs and has TIMEOUT=0.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_apb_master_bridge;

   logic        pclk = 1'b0;
   logic        prstn;
   logic        req_i, we_i;
   logic [3:0]  be_i;
   logic [31:0] addr_i, wdata_i;
   logic [31:0] prdata;
   logic        pready, pslverr;

   // TIMEOUT=8 instance
   logic        gnt_o, rvalid_o, err_o, psel, penable, pwrite;
   logic [31:0] rdata_o, paddr, pwdata;
   logic [3:0]  pstrb;
   // TIMEOUT=0 instance
   logic        gnt_z, rvalid_z, err_z, psel_z, penable_z, pwrite_z;
   logic [31:0] rdata_z, paddr_z, pwdata_z;
   logic [3:0]  pstrb_z;

   int n_checks = 0;
   int n_fail   = 0;

   apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) u_dut (
      .pclk(pclk), .prstn(prstn), .req_i(req_i), .we_i(we_i), .be_i(be_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
      .rdata_o(rdata_o), .err_o(err_o), .psel(psel), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) u_dut_nowd (
      .pclk(pclk), .prstn(prstn), .req_i(req_i), .we_i(we_i), .be_i(be_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_z), .rvalid_o(rvalid_z),
      .rdata_o(rdata_z), .err_o(err_z), .psel(psel_z), .penable(penable_z),
      .pwrite(pwrite_z), .paddr(paddr_z), .pwdata(pwdata_z), .pstrb(pstrb_z),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 pclk = ~pclk;

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata);
      req_i   = 1'b1;
      we_i    = we;
      be_i    = be;
      addr_i  = addr;
      wdata_i = wdata;
   endtask

   initial begin
      prstn = 1'b0; req_i = 1'b0; we_i = 1'b0; be_i = '0; addr_i = '0; wdata_i = '0;
      prdata = '0; pready = 1'b0; pslverr = 1'b0;
      step(); step();

      // ---- reset state
      chk("rst_psel", {31'd0, psel}, 32'd0);
      chk("rst_penable", {31'd0, penable}, 32'd0);
      chk("rst_pwrite", {31'd0, pwrite}, 32'd0);
      chk("rst_paddr", paddr, 32'd0);
      chk("rst_pwdata", pwdata, 32'd0);
      chk("rst_pstrb", {28'd0, pstrb}, 32'd0);
      chk("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
      chk("rst_rdata", rdata_o, 32'd0);
      chk("rst_err", {31'd0, err_o}, 32'd0);
      chk("rst_gnt", {31'd0, gnt_o}, 32'd0);
      prstn = 1'b1;
      step();

      // ---- zero-wait write
      drive_req(1'b1, 4'hF, 32'h1000_0004, 32'h1234_5678);
      pready = 1'b1;
      #1 chk("wr_gnt", {31'd0, gnt_o}, 32'd1);
      step();                                   // cycle 1: SETUP
      req_i = 1'b0;
      chk("wr_setup_psel", {31'd0, psel}, 32'd1);
      chk("wr_setup_penable", {31'd0, penable}, 32'd0);
      chk("wr_setup_paddr", paddr, 32'h1000_0004);
      chk("wr_setup_pstrb", {28'd0, pstrb}, 32'hF);
      chk("wr_setup_pwrite", {31'd0, pwrite}, 32'd1);
      chk("wr_setup_pwdata", pwdata, 32'h1234_5678);
      chk("wr_setup_gnt", {31'd0, gnt_o}, 32'd0);
      step();                                   // cycle 2: ACCESS
      chk("wr_acc_penable", {31'd0, penable}, 32'd1);
      chk("wr_acc_rvalid", {31'd0, rvalid_o}, 32'd0);
      step();                                   // cycle 3: response
      chk("wr_rvalid", {31'd0, rvalid_o}, 32'd1);
      chk("wr_err", {31'd0, err_o}, 32'd0);
      chk("wr_rdata", rdata_o, 32'd0);
      chk("wr_psel_done", {31'd0, psel}, 32'd0);
      chk("wr_paddr_hold", paddr, 32'h1000_0004);
      step();
      chk("wr_rvalid_1cyc", {31'd0, rvalid_o}, 32'd0);

      // ---- read with 4 wait states
      drive_req(1'b0, 4'hF, 32'h1000_0000, 32'hFFFF_FFFF);
      pready = 1'b0;
      prdata = 32'hCAFE_F00D;
      step();                                   // SETUP
      req_i = 1'b0;
      chk("rd_setup_pwrite", {31'd0, pwrite}, 32'd0);
      chk("rd_setup_pstrb", {28'd0, pstrb}, 32'd0);
      chk("rd_setup_paddr", paddr, 32'h1000_0000);
      for (int i = 0; i < 5; i++) begin
         step();                                // ACCESS cycles 1..5
         chk("rd_acc_penable", {31'd0, psel & penable}, 32'd1);
         chk("rd_acc_pstrb", {28'd0, pstrb}, 32'd0);
         chk("rd_acc_rvalid", {31'd0, rvalid_o}, 32'd0);
         if (i == 4) pready = 1'b1;
      end
      step();
      pready = 1'b0;
      chk("rd_rvalid", {31'd0, rvalid_o}, 32'd1);
      chk("rd_rdata", rdata_o, 32'hCAFE_F00D);
      chk("rd_err", {31'd0, err_o}, 32'd0);
      chk("rd_psel_done", {31'd0, psel}, 32'd0);
      step();
      chk("rd_rvalid_1cyc", {31'd0, rvalid_o}, 32'd0);
      chk("rd_rdata_hold", rdata_o, 32'hCAFE_F00D);

      // ---- read with slave error, then back-to-back write clears err
      drive_req(1'b0, 4'hF, 32'h0000_0020, 32'd0);
      pready = 1'b1; pslverr = 1'b1; prdata = 32'h0000_0055;
      step(); req_i = 1'b0;                     // SETUP
      step();                                   // ACCESS
      step();                                   // response
      chk("se_rvalid", {31'd0, rvalid_o}, 32'd1);
      chk("se_err", {31'd0, err_o}, 32'd1);
      chk("se_rdata", rdata_o, 32'h0000_0055);
      pslverr = 1'b0;
      drive_req(1'b1, 4'hF, 32'h0000_0024, 32'hA5A5_A5A5);
      #1 chk("se_next_gnt", {31'd0, gnt_o}, 32'd1);
      step(); req_i = 1'b0;                     // SETUP
      chk("se_err_hold", {31'd0, err_o}, 32'd1);
      step();                                   // ACCESS
      step();
      chk("se_next_rvalid", {31'd0, rvalid_o}, 32'd1);
      chk("se_next_err", {31'd0, err_o}, 32'd0);
      step();

      // ---- watchdog: pready stuck low
      drive_req(1'b0, 4'hF, 32'h0000_0040, 32'd0);
      pready = 1'b0; prdata = 32'hDEAD_BEEF;
      step(); req_i = 1'b0;                     // SETUP
      for (int i = 0; i < 8; i++) begin
         step();                                // ACCESS cycles 1..8
         chk("wd_acc_penable", {31'd0, psel & penable}, 32'd1);
      end
      step();
      chk("wd_psel", {31'd0, psel}, 32'd0);
      chk("wd_penable", {31'd0, penable}, 32'd0);
      chk("wd_rvalid", {31'd0, rvalid_o}, 32'd1);
      chk("wd_err", {31'd0, err_o}, 32'd1);
      chk("wd_rdata", rdata_o, 32'd0);
      chk("nowd_still_access", {31'd0, psel_z & penable_z}, 32'd1);
      for (int i = 0; i < 12; i++) step();
      chk("nowd_long_access", {31'd0, psel_z & penable_z}, 32'd1);
      chk("nowd_no_rvalid", {31'd0, rvalid_z}, 32'd0);
      chk("wd_idle_after", {31'd0, psel}, 32'd0);
      pready = 1'b1; prdata = 32'h0000_0077;
      step();
      pready = 1'b0;
      chk("nowd_rvalid", {31'd0, rvalid_z}, 32'd1);
      chk("nowd_rdata", rdata_z, 32'h0000_0077);
      chk("nowd_err", {31'd0, err_z}, 32'd0);
      chk("wd_ignores_pready", {31'd0, rvalid_o}, 32'd0);
      step();

      // ---- three back-to-back writes with req held
      pready = 1'b1;
      drive_req(1'b1, 4'hF, 32'h0000_0000, 32'h1111_1111);
      #1 chk("b2b_gnt0", {31'd0, gnt_o}, 32'd1);
      step();
      chk("b2b_paddr0", paddr, 32'h0000_0000);
      chk("b2b_gnt_setup", {31'd0, gnt_o}, 32'd0);
      addr_i = 32'h0000_0004; wdata_i = 32'h2222_2222;
      step();
      chk("b2b_gnt_access", {31'd0, gnt_o}, 32'd0);
      step();
      chk("b2b_rvalid0", {31'd0, rvalid_o}, 32'd1);
      chk("b2b_gnt1", {31'd0, gnt_o}, 32'd1);
      step();
      chk("b2b_paddr1", paddr, 32'h0000_0004);
      chk("b2b_pwdata1", pwdata, 32'h2222_2222);
      addr_i = 32'h0000_000A; be_i = 4'h3; wdata_i = 32'h3333_3333;
      step();
      step();
      chk("b2b_rvalid1", {31'd0, rvalid_o}, 32'd1);
      chk("b2b_gnt2", {31'd0, gnt_o}, 32'd1);
      step();
      req_i = 1'b0;
      chk("b2b_paddr2", paddr, 32'h0000_0008);
      chk("b2b_pstrb2", {28'd0, pstrb}, 32'h3);
      step();
      step();
      chk("b2b_rvalid2", {31'd0, rvalid_o}, 32'd1);
      step();
      pready = 1'b0;

      // ---- reset during ACCESS
      drive_req(1'b0, 4'hF, 32'h0000_0080, 32'd0);
      step(); req_i = 1'b0;                     // SETUP
      step();                                   // ACCESS
      chk("rst_mid_access", {31'd0, psel & penable}, 32'd1);
      prstn = 1'b0;
      #1;
      chk("rst_mid_psel", {31'd0, psel}, 32'd0);
      chk("rst_mid_penable", {31'd0, penable}, 32'd0);
      step();
      chk("rst_mid_rvalid", {31'd0, rvalid_o}, 32'd0);
      prstn = 1'b1;
      pready = 1'b1;
      step();
      chk("rst_mid_rvalid_after", {31'd0, rvalid_o}, 32'd0);
      pready = 1'b0;

      // ---- write with no byte enables: local completion, no APB cycle
      drive_req(1'b1, 4'h0, 32'h0000_0100, 32'hFFFF_0000);
      #1 chk("be0_gnt", {31'd0, gnt_o}, 32'd1);
      step();
      req_i = 1'b0;
      chk("be0_rvalid", {31'd0, rvalid_o}, 32'd1);
      chk("be0_err", {31'd0, err_o}, 32'd0);
      chk("be0_rdata", rdata_o, 32'd0);
      chk("be0_psel", {31'd0, psel}, 32'd0);
      chk("be0_paddr_unchanged", paddr, 32'd0);
      step();
      chk("be0_rvalid_1cyc", {31'd0, rvalid_o}, 32'd0);
      chk("be0_psel_after", {31'd0, psel}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
